traffic_phase_scheduler: RTL
============================

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- T_MIN_GREEN, 8, minimum green cycles.
- T_MAX_COUNTY, 20, maximum county green cycles.
- T_YELLOW, 3, yellow cycles.
- T_ALLRED, 2, all-red cycles.
- T_WALK, 6, pedestrian walk cycles.
- All parameters are in the range 1..255.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, the single clock; rising edge.
- reset, in, 1, asynchronous, active-low reset; 0 resets.
- x, in, 1, county-road vehicle sensor.
- ped_req, in, 1, pedestrian button, level.
- emg_req, in, 1, emergency preempt, level.
- emg_dir, in, 1, preempt direction: 0 = main, 1 = county.
- main_road, out, 8, main lamp code.
- county_road, out, 8, county lamp code.
- ped_walk, out, 1, walk lamp.
- ped_ack, out, 1, one-cycle pedestrian grant pulse.
- phase, out, 3, current state encoding.

Function
REQ-003 Lamp codes SHALL be 8'h01 red, 8'h02 yellow and 8'h04 green; no other values are legal.

REQ-004 States and phase encodings SHALL be:
- MG=0 (main green, county red)
- MY=1 (main yellow, county red)
- AR1=2 (both red)
- CG=3 (main red, county green)
- CY=4 (main red, county yellow)
- AR2=5 (both red)
- PW=6 (both red, ped_walk=1)
- EG=7 (emergency direction green, other road red)

REQ-005 All outputs SHALL be Moore outputs decoded from the registered state only.

REQ-006 The timer SHALL be 8-bit. It clears to 0 on every state change, increments otherwise and saturates at 255.

REQ-007 Timed exits SHALL occur when timer == T-1, so each timed state lasts exactly T cycles.

REQ-008 x_pend SHALL set when x=1 in any state except CG, and SHALL clear on entry to CG.

REQ-009 ped_pend SHALL set when ped_req=1 in any state except PW, and SHALL clear on entry to PW.

REQ-010 emg_dir SHALL be captured into emg_q on the first cycle emg_req is high, and held while emg_req stays high.

REQ-011 Transitions with no emergency pending SHALL be:
- MG -> MY when timer >= T_MIN_GREEN-1 and (x_pend or ped_pend); otherwise MG holds indefinitely.
- MY -> AR1 after T_YELLOW.
- AR1 -> CG after T_ALLRED if x_pend; otherwise -> PW.
- CG -> CY when timer == T_MAX_COUNTY-1, or when timer >= T_MIN_GREEN-1 and x=0 (gap-out).
- CY -> AR2 after T_YELLOW.
- AR2 -> PW after T_ALLRED if ped_pend; otherwise -> MG.
- PW -> MG after T_WALK.

REQ-012 Emergency handling SHALL take priority over REQ-011:
- MG with emg_q=0 -> EG.
- MG with emg_q=1 -> MY immediately.
- CG with emg_q=1 -> EG.
- CG with emg_q=0 -> CY immediately.
- PW -> AR2 immediately.
- MY, CY, AR1, AR2 complete their timing, then all-red exits go to EG.

REQ-013 In EG the lamps SHALL show green on emg_q's road. On emg_req=0, EG SHALL exit to MY (emg_q=0) or CY (emg_q=1).

REQ-014 ped_ack SHALL be 1 for exactly the first cycle of PW.

REQ-015 When x and ped_pend are simultaneous at AR1, county SHALL be served first, then PW via AR2.

REQ-016 No transition SHALL ever go from green directly to the other road's green, except in the EG cases listed in REQ-012.

Reset
REQ-017 On reset=0, asynchronously and regardless of current state:
- state=MG, timer=0, x_pend=0, ped_pend=0, emg_q=0.
- main_road=8'h04, county_road=8'h01, ped_walk=0, ped_ack=0, phase=0.

REQ-018 Operation SHALL resume at the first rising clk edge after reset returns to 1.

Verification
REQ-019 Benches SHALL cover the following directed scenarios:
- Idle: release reset, x=0, ped_req=0, emg_req=0 for 100 cycles -> phase stays 0, main_road=8'h04 throughout.
- Car gap-out: 1-cycle x pulse at cycle 2 -> MG 8 cycles, MY 3, AR1 2, CG 8, CY 3, AR2 2, then MG.
- Car max-out: x held 1 -> CG lasts exactly 20 cycles, then CY.
- Pedestrian: 1-cycle ped_req, x=0 -> MG 8, MY 3, AR1 2, PW 6 with ped_walk=1, ped_ack high only in PW cycle 1, then MG.
- Preempt: in CG cycle 3, emg_req=1 with emg_dir=0 -> CY next cycle, then AR2, then EG with main_road=8'h04; drop emg_req -> MY.
- Reset mid-operation: reset=0 during CY cycle 2 -> main_road=8'h04 and county_road=8'h01 before the next clk edge; pending latches cleared.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Main/county intersection controller with pedestrian phase and emergency preempt.
// Lamp and walk outputs are decoded from the state, dwell timer and captured preempt direction.
module traffic_phase_scheduler #(
    parameter int T_MIN_GREEN  = 8,
    parameter int T_MAX_COUNTY = 20,
    parameter int T_YELLOW     = 3,
    parameter int T_ALLRED     = 2,
    parameter int T_WALK       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic       ped_req,
    input  logic       emg_req,
    input  logic       emg_dir,
    output logic [7:0] main_road,
    output logic [7:0] county_road,
    output logic       ped_walk,
    output logic       ped_ack,
    output logic [2:0] phase
);
    // state | meaning
    // MG    | main green, county red
    // MY    | main yellow, county red
    // AR1   | all red after main
    // CG    | county green, main red
    // CY    | county yellow, main red
    // AR2   | all red after county
    // PW    | all red, pedestrian walk
    // EG    | emergency road green, other red
    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5,
        PW  = 3'd6,
        EG  = 3'd7
    } state_t;

    localparam logic [7:0] LAMP_RED    = 8'h01;
    localparam logic [7:0] LAMP_YELLOW = 8'h02;
    localparam logic [7:0] LAMP_GREEN  = 8'h04;

    localparam logic [7:0] MIN_GREEN_TC  = 8'(T_MIN_GREEN - 1);
    localparam logic [7:0] MAX_COUNTY_TC = 8'(T_MAX_COUNTY - 1);
    localparam logic [7:0] YELLOW_TC     = 8'(T_YELLOW - 1);
    localparam logic [7:0] ALLRED_TC     = 8'(T_ALLRED - 1);
    localparam logic [7:0] WALK_TC       = 8'(T_WALK - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] timer;
    logic       x_pend;
    logic       ped_pend;
    logic       emg_q;
    logic       emg_seen;
    logic       emg_dir_eff;

    // On the first preempt cycle emg_q is not yet loaded, so steer from the live direction.
    assign emg_dir_eff = (emg_req && !emg_seen) ? emg_dir : emg_q;

    always_comb begin
        state_nxt = state;
        case (state)
            MG: begin
                if (emg_req)
                    state_nxt = emg_dir_eff ? MY : EG;
                else if (timer >= MIN_GREEN_TC && (x_pend || ped_pend))
                    state_nxt = MY;
            end
            MY: begin
                if (timer == YELLOW_TC)
                    state_nxt = AR1;
            end
            AR1: begin
                if (timer == ALLRED_TC)
                    state_nxt = emg_req ? EG : (x_pend ? CG : PW);
            end
            CG: begin
                if (emg_req)
                    state_nxt = emg_dir_eff ? EG : CY;
                else if (timer == MAX_COUNTY_TC || (timer >= MIN_GREEN_TC && !x))
                    state_nxt = CY;
            end
            CY: begin
                if (timer == YELLOW_TC)
                    state_nxt = AR2;
            end
            AR2: begin
                if (timer == ALLRED_TC)
                    state_nxt = emg_req ? EG : (ped_pend ? PW : MG);
            end
            PW: begin
                if (emg_req)
                    state_nxt = AR2;
                else if (timer == WALK_TC)
                    state_nxt = MG;
            end
            EG: begin
                if (!emg_req)
                    state_nxt = emg_q ? CY : MY;
            end
            default: state_nxt = MG;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= MG;
            timer    <= 8'd0;
            x_pend   <= 1'b0;
            ped_pend <= 1'b0;
            emg_q    <= 1'b0;
            emg_seen <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state)
                timer <= 8'd0;
            else if (timer != 8'hFF)
                timer <= timer + 8'd1;

            if (state_nxt == CG && state != CG)
                x_pend <= 1'b0;
            else if (x && state != CG)
                x_pend <= 1'b1;

            if (state_nxt == PW && state != PW)
                ped_pend <= 1'b0;
            else if (ped_req && state != PW)
                ped_pend <= 1'b1;

            emg_seen <= emg_req;
            if (emg_req && !emg_seen)
                emg_q <= emg_dir;
        end
    end

    always_comb begin
        main_road   = LAMP_RED;
        county_road = LAMP_RED;
        case (state)
            MG:      main_road   = LAMP_GREEN;
            MY:      main_road   = LAMP_YELLOW;
            CG:      county_road = LAMP_GREEN;
            CY:      county_road = LAMP_YELLOW;
            EG: begin
                if (emg_q)
                    county_road = LAMP_GREEN;
                else
                    main_road   = LAMP_GREEN;
            end
            default: begin
                main_road   = LAMP_RED;
                county_road = LAMP_RED;
            end
        endcase
    end

    assign ped_walk = (state == PW);
    assign ped_ack  = (state == PW) && (timer == 8'd0);
    assign phase    = state;

endmodule
